// File: rtl/sysid_ext_pkg.sv
// Shared constants for the sysid_ext slave: word map, CONTROL bits, CAPS layout, address decode.
// Pure declarations; no latency or flow-control behaviour lives here.
package sysid_ext_pkg;

  localparam int DATA_W = 32;

  localparam int ADDR_ID        = 0;
  localparam int ADDR_TIMESTAMP = 1;
  localparam int ADDR_SCRATCH   = 2;
  localparam int ADDR_CAPS      = 3;
  localparam int ADDR_UPTIME_LO = 4;
  localparam int ADDR_UPTIME_HI = 5;
  localparam int ADDR_CONTROL   = 6;
  localparam int ADDR_RESERVED  = 7;
  localparam int ADDR_USER_BASE = 8;
  localparam int MAX_USER       = 8;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  localparam int CAPS_NUM_USER_LSB = 0;
  localparam int CAPS_UPTIME_W_LSB = 8;
  localparam int CAPS_FIELD_W      = 8;

  typedef enum logic [3:0] {
    REG_ID,
    REG_TIMESTAMP,
    REG_SCRATCH,
    REG_CAPS,
    REG_UPTIME_LO,
    REG_UPTIME_HI,
    REG_CONTROL,
    REG_USER,
    REG_NONE
  } reg_sel_e;

  function automatic logic [DATA_W-1:0] caps_word(input int uptime_w, input int num_user);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CAPS_UPTIME_W_LSB +: CAPS_FIELD_W] = CAPS_FIELD_W'(uptime_w);
    w[CAPS_NUM_USER_LSB +: CAPS_FIELD_W] = CAPS_FIELD_W'(num_user);
    return w;
  endfunction

  // Reserved word 7 and everything past the last user word fall through to REG_NONE.
  function automatic reg_sel_e decode_addr(input logic [31:0] a, input int num_user);
    reg_sel_e s;
    s = REG_NONE;
    case (a)
      32'(ADDR_ID):        s = REG_ID;
      32'(ADDR_TIMESTAMP): s = REG_TIMESTAMP;
      32'(ADDR_SCRATCH):   s = REG_SCRATCH;
      32'(ADDR_CAPS):      s = REG_CAPS;
      32'(ADDR_UPTIME_LO): s = REG_UPTIME_LO;
      32'(ADDR_UPTIME_HI): s = REG_UPTIME_HI;
      32'(ADDR_CONTROL):   s = REG_CONTROL;
      default: begin
        if (a >= 32'(ADDR_USER_BASE) && a < 32'(ADDR_USER_BASE + num_user)) begin
          s = REG_USER;
        end
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sysid_ext_if.sv
// Avalon-MM style slave bus for sysid_ext: address/read/write/writedata in, readdata/readdatavalid out.
// Read latency 1, no waitrequest; the slave never backpressures.
interface sysid_ext_if
  import sysid_ext_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
);

  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  write;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with clear, load and freeze; wraps from all-ones to zero.
// Clear/load take effect on the next edge; counting never stalls the bus.
module sysid_uptime_counter #(
  parameter int UPTIME_WIDTH = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load,
  input  logic [UPTIME_WIDTH-1:0] load_value,
  input  logic                    freeze,
  output logic [UPTIME_WIDTH-1:0] count
);

  logic [UPTIME_WIDTH-1:0] count_q;
  logic [UPTIME_WIDTH-1:0] count_d;

  // Clear beats load beats increment; reset is handled in the register itself.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (!freeze) begin
      count_d = count_q + UPTIME_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sysid_ext.sv
// System-ID slave: ID/timestamp/caps/user words, scratch, and a loadable uptime counter with coherent 64-bit read.
// Fixed read latency 1 with no waitrequest; every access is accepted in the cycle it is presented.
module sysid_ext
  import sysid_ext_pkg::*;
#(
  parameter logic [31:0]            ID_VALUE      = 32'h0,
  parameter logic [31:0]            TIMESTAMP     = 32'h0,
  parameter int                     NUM_USER      = 4,
  parameter logic [32*NUM_USER-1:0] USER_INFO     = {NUM_USER{32'h0}},
  parameter int                     UPTIME_WIDTH  = 64,
  parameter logic [31:0]            SCRATCH_RESET = 32'h0,
  parameter int                     ADDR_WIDTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  sysid_ext_if.slave  bus
);

  localparam logic [DATA_W-1:0]       CAPS_VALUE = caps_word(UPTIME_WIDTH, NUM_USER);
  localparam logic [32*MAX_USER-1:0]  USER_PAD   = (32*MAX_USER)'(USER_INFO);

  logic [DATA_W-1:0] scratch_q,       scratch_d;
  logic [DATA_W-1:0] hi_stage_q,      hi_stage_d;
  logic [DATA_W-1:0] hi_shadow_q,     hi_shadow_d;
  logic              freeze_q,        freeze_d;
  logic [DATA_W-1:0] readdata_q,      readdata_d;
  logic              readdatavalid_q, readdatavalid_d;

  logic [31:0]             addr_u;
  reg_sel_e                sel;
  logic [2:0]              user_idx;
  logic [DATA_W-1:0]       rd_word;
  logic                    cnt_clear;
  logic                    cnt_load;
  logic [63:0]             load_full;
  logic [UPTIME_WIDTH-1:0] load_value;
  logic [UPTIME_WIDTH-1:0] count;
  logic [63:0]             count_ext;

  always_comb begin
    addr_u   = 32'(bus.address);
    sel      = decode_addr(addr_u, NUM_USER);
    user_idx = 3'(addr_u - 32'(ADDR_USER_BASE));
  end

  always_comb begin
    count_ext                   = '0;
    count_ext[UPTIME_WIDTH-1:0] = count;
  end

  // The HI_STAGE word supplies the upper bits of a load; bits beyond the counter width are dropped.
  assign load_full  = {hi_stage_q, bus.writedata};
  assign load_value = load_full[UPTIME_WIDTH-1:0];

  always_comb begin
    rd_word = '0;
    unique case (sel)
      REG_ID:        rd_word = ID_VALUE;
      REG_TIMESTAMP: rd_word = TIMESTAMP;
      REG_SCRATCH:   rd_word = scratch_q;
      REG_CAPS:      rd_word = CAPS_VALUE;
      REG_UPTIME_LO: rd_word = count_ext[31:0];
      REG_UPTIME_HI: rd_word = hi_shadow_q;
      REG_CONTROL:   rd_word[CTRL_FREEZE_BIT] = freeze_q;
      REG_USER:      rd_word = USER_PAD[32*user_idx +: 32];
      default:       rd_word = '0;
    endcase
  end

  // Read data is taken from pre-edge state, so a same-cycle write never leaks into the read.
  always_comb begin
    scratch_d       = scratch_q;
    hi_stage_d      = hi_stage_q;
    hi_shadow_d     = hi_shadow_q;
    freeze_d        = freeze_q;
    cnt_clear       = 1'b0;
    cnt_load        = 1'b0;
    readdatavalid_d = bus.read;
    readdata_d      = bus.read ? rd_word : '0;

    if (bus.read && sel == REG_UPTIME_LO) begin
      hi_shadow_d = count_ext[63:32];
    end

    if (bus.write) begin
      unique case (sel)
        REG_SCRATCH:   scratch_d  = bus.writedata;
        REG_UPTIME_LO: cnt_load   = 1'b1;
        REG_UPTIME_HI: hi_stage_d = bus.writedata;
        REG_CONTROL: begin
          cnt_clear = bus.writedata[CTRL_CLEAR_BIT];
          freeze_d  = bus.writedata[CTRL_FREEZE_BIT];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q       <= SCRATCH_RESET;
      hi_stage_q      <= '0;
      hi_shadow_q     <= '0;
      freeze_q        <= 1'b0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      scratch_q       <= scratch_d;
      hi_stage_q      <= hi_stage_d;
      hi_shadow_q     <= hi_shadow_d;
      freeze_q        <= freeze_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  sysid_uptime_counter #(
    .UPTIME_WIDTH (UPTIME_WIDTH)
  ) u_uptime (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .load_value (load_value),
    .freeze     (freeze_q),
    .count      (count)
  );

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = readdatavalid_q;

endmodule

// File: tb/tb_sysid_ext.sv
// Self-checking bench for sysid_ext: directed scenarios plus a randomized run against a time-based reference model.
module tb_sysid_ext;

  localparam logic [31:0]  ID_V   = 32'h5121_C0BB;
  localparam logic [31:0]  TS_V   = 32'h1361_0000;
  localparam logic [31:0]  SCR_RV = 32'hA5A5_0001;
  localparam logic [127:0] USER_V = {32'hCAFE_0003, 32'h1234_0002, 32'h8765_0001, 32'h0BAD_F00D};

  logic clock = 1'b0;
  logic reset = 1'b0;
  sysid_ext_if #(.ADDR_WIDTH(4)) bus();

  sysid_ext #(
    .ID_VALUE      (ID_V),
    .TIMESTAMP     (TS_V),
    .NUM_USER      (4),
    .USER_INFO     (USER_V),
    .UPTIME_WIDTH  (64),
    .SCRATCH_RESET (SCR_RV),
    .ADDR_WIDTH    (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference state: the counter is "m_base at cycle m_base_n", running or frozen from there on.
  logic [63:0] m_base;
  int          m_base_n;
  bit          m_frozen;
  logic [31:0] m_scratch, m_hi_stage, m_shadow;
  logic [31:0] user_w [4];

  function automatic logic [63:0] cnt_at(input int n);
    if (m_frozen) return m_base;
    return m_base + 64'(n - m_base_n);
  endfunction

  function automatic logic [31:0] m_read(input int a, input int n);
    logic [63:0] c;
    c = cnt_at(n);
    case (a)
      0: return ID_V;
      1: return TS_V;
      2: return m_scratch;
      3: return 32'h0000_4004;
      4: return c[31:0];
      5: return m_shadow;
      6: return m_frozen ? 32'h2 : 32'h0;
      8, 9, 10, 11: return user_w[a-8];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset(input int k);
    m_base = 64'h0; m_base_n = k + 1; m_frozen = 1'b0;
    m_scratch = SCR_RV; m_hi_stage = 32'h0; m_shadow = 32'h0;
  endtask

  task automatic model_apply(input bit rd, input bit wr, input int a, input logic [31:0] wd, input int k);
    logic [63:0] c;
    c = cnt_at(k);
    if (rd && a == 4) m_shadow = c[63:32];
    if (wr) begin
      case (a)
        2: m_scratch = wd;
        4: begin m_base = {m_hi_stage, wd}; m_base_n = k + 1; end
        5: m_hi_stage = wd;
        6: begin
          m_base   = wd[0] ? 64'h0 : cnt_at(k + 1);
          m_base_n = k + 1;
          m_frozen = wd[1];
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  // One bus cycle: drive, predict, clock, then sample the registered response of this very access.
  task automatic access(input bit rst, input bit rd, input bit wr, input logic [3:0] a,
                        input logic [31:0] wd, output logic [31:0] got_d, output logic got_v,
                        output logic [31:0] exp_d, output logic exp_v);
    int k;
    k = cyc;
    reset = rst; bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;
    exp_v = rd && !rst;
    exp_d = exp_v ? m_read(int'(a), k) : 32'h0;
    if (rst) model_reset(k);
    else     model_apply(rd, wr, int'(a), wd, k);
    step();
    got_d = bus.readdata;
    got_v = bus.readdatavalid;
    reset = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
  endtask

  logic [31:0] gd, ed;
  logic        gv, ev;

  task automatic idle(input int n);
    repeat (n) access(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, gd, gv, ed, ev);
  endtask

  task automatic do_reset(input int n);
    repeat (n) access(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, gd, gv, ed, ev);
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
      failures++; $display("FAIL reset_outputs: valid=%b data=%h want valid=0 data=0", bus.readdatavalid, bus.readdata);
    end
    access(0, 1, 0, 4'd5, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== 32'h0) begin failures++; $display("FAIL reset_hi_shadow: got %b/%h want 1/0", gv, gd); end
    access(0, 1, 0, 4'd2, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== SCR_RV) begin failures++; $display("FAIL reset_scratch: got %b/%h want 1/%h", gv, gd, SCR_RV); end
    access(0, 1, 0, 4'd6, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== 32'h0) begin failures++; $display("FAIL reset_control: got %b/%h want 1/0", gv, gd); end
    access(0, 1, 0, 4'd4, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== ed) begin failures++; $display("FAIL reset_uptime_lo: got %b/%h want 1/%h", gv, gd, ed); end
  endtask

  task automatic test_id_caps();
    access(0, 1, 0, 4'd0, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== 32'h5121_C0BB) begin failures++; $display("FAIL id_read: got %b/%h want 1/5121c0bb", gv, gd); end
    access(0, 1, 0, 4'd1, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== 32'h1361_0000) begin failures++; $display("FAIL timestamp_read: got %b/%h want 1/13610000", gv, gd); end
    idle(1); checks++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
      failures++; $display("FAIL idle_after_read: valid=%b data=%h want 0/0", bus.readdatavalid, bus.readdata);
    end
    access(0, 0, 1, 4'd0, $urandom, gd, gv, ed, ev);
    access(0, 1, 0, 4'd0, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== 32'h5121_C0BB) begin failures++; $display("FAIL id_write_ignored: got %b/%h want 1/5121c0bb", gv, gd); end
    access(0, 1, 0, 4'd3, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== 32'h0000_4004) begin failures++; $display("FAIL caps_read: got %b/%h want 1/00004004", gv, gd); end
  endtask

  task automatic test_scratch();
    logic [31:0] v;
    for (int i = 0; i < 6; i++) begin
      v = (i == 0) ? 32'hDEAD_BEEF : $urandom;
      access(0, 0, 1, 4'd2, v, gd, gv, ed, ev);
      access(0, 1, 0, 4'd2, 0, gd, gv, ed, ev); checks++;
      if (gv !== 1'b1 || gd !== v) begin failures++; $display("FAIL scratch_rw[%0d]: got %b/%h want 1/%h", i, gv, gd, v); end
    end
    do_reset(1);
    access(0, 1, 0, 4'd2, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== SCR_RV) begin failures++; $display("FAIL scratch_after_reset: got %b/%h want 1/%h", gv, gd, SCR_RV); end
  endtask

  task automatic test_uptime_wrap();
    access(0, 0, 1, 4'd5, 32'h0000_0001, gd, gv, ed, ev);
    access(0, 0, 1, 4'd4, 32'hFFFF_FFF0, gd, gv, ed, ev);
    idle(5);
    access(0, 1, 0, 4'd4, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== 32'hFFFF_FFF5) begin failures++; $display("FAIL wrap_lo: got %b/%h want 1/fffffff5", gv, gd); end
    idle(40);
    access(0, 1, 0, 4'd5, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== 32'h1) begin failures++; $display("FAIL wrap_hi_coherent: got %b/%h want 1/00000001", gv, gd); end
    access(0, 1, 0, 4'd5, 0, gd, gv, ed, ev); checks++;
    if (gd !== 32'h1) begin failures++; $display("FAIL hi_without_lo: got %h want 00000001", gd); end
    access(0, 1, 0, 4'd4, 0, gd, gv, ed, ev); checks++;
    if (gd !== ed) begin failures++; $display("FAIL post_wrap_lo: got %h want %h", gd, ed); end
    access(0, 1, 0, 4'd5, 0, gd, gv, ed, ev); checks++;
    if (gd !== 32'h2) begin failures++; $display("FAIL post_wrap_hi: got %h want 00000002", gd); end
  endtask

  task automatic test_freeze_clear();
    logic [31:0] first;
    access(0, 0, 1, 4'd6, 32'h2, gd, gv, ed, ev);
    access(0, 1, 0, 4'd4, 0, gd, gv, ed, ev); first = gd; checks++;
    if (gd !== ed) begin failures++; $display("FAIL freeze_lo_a: got %h want %h", gd, ed); end
    idle(10);
    access(0, 1, 0, 4'd4, 0, gd, gv, ed, ev); checks++;
    if (gd !== first || gd !== ed) begin failures++; $display("FAIL freeze_holds: got %h want %h", gd, ed); end
    access(0, 0, 1, 4'd6, 32'h3, gd, gv, ed, ev);
    access(0, 1, 0, 4'd4, 0, gd, gv, ed, ev); checks++;
    if (gd !== 32'h0) begin failures++; $display("FAIL clear_freeze_lo: got %h want 00000000", gd); end
    access(0, 1, 0, 4'd6, 0, gd, gv, ed, ev); checks++;
    if (gd !== 32'h2) begin failures++; $display("FAIL control_readback: got %h want 00000002", gd); end
    access(0, 0, 1, 4'd6, 32'h0, gd, gv, ed, ev);
    access(0, 1, 0, 4'd4, 0, gd, gv, ed, ev); checks++;
    if (gd !== 32'h0) begin failures++; $display("FAIL unfreeze_first: got %h want 00000000", gd); end
    idle(3);
    access(0, 1, 0, 4'd4, 0, gd, gv, ed, ev); checks++;
    if (gd !== 32'h4) begin failures++; $display("FAIL unfreeze_counts: got %h want 00000004", gd); end
  endtask

  task automatic test_rw_same();
    logic [31:0] v;
    access(0, 0, 1, 4'd2, 32'h1, gd, gv, ed, ev);
    access(0, 1, 1, 4'd2, 32'h2, gd, gv, ed, ev); checks++;
    if (gv !== 1'b1 || gd !== 32'h1) begin failures++; $display("FAIL rw_same_old: got %b/%h want 1/00000001", gv, gd); end
    access(0, 1, 0, 4'd2, 0, gd, gv, ed, ev); checks++;
    if (gd !== 32'h2) begin failures++; $display("FAIL rw_same_new: got %h want 00000002", gd); end
    v = $urandom;
    access(0, 0, 1, 4'd5, $urandom, gd, gv, ed, ev);
    access(0, 1, 1, 4'd4, v, gd, gv, ed, ev); checks++;
    if (gd !== ed) begin failures++; $display("FAIL rw_same_lo_old: got %h want %h", gd, ed); end
    access(0, 1, 0, 4'd5, 0, gd, gv, ed, ev); checks++;
    if (gd !== ed) begin failures++; $display("FAIL rw_same_lo_shadow: got %h want %h", gd, ed); end
    access(0, 1, 0, 4'd4, 0, gd, gv, ed, ev); checks++;
    if (gd !== v + 32'd1) begin failures++; $display("FAIL rw_same_lo_loaded: got %h want %h", gd, v + 32'd1); end
  endtask

  task automatic test_user();
    for (int a = 8; a < 12; a++) begin
      access(0, 1, 0, 4'(a), 0, gd, gv, ed, ev); checks++;
      if (gv !== 1'b1 || gd !== user_w[a-8]) begin failures++; $display("FAIL user_word[%0d]: got %b/%h want 1/%h", a, gv, gd, user_w[a-8]); end
    end
    access(0, 0, 1, 4'd11, $urandom, gd, gv, ed, ev);
    access(0, 1, 0, 4'd11, 0, gd, gv, ed, ev); checks++;
    if (gd !== 32'hCAFE_0003) begin failures++; $display("FAIL user_write_ignored: got %h want cafe0003", gd); end
    foreach (user_w[i]) begin
      logic [3:0] a;
      a = (i == 0) ? 4'd7 : 4'(11 + i);
      access(0, 1, 0, a, 0, gd, gv, ed, ev); checks++;
      if (gv !== 1'b1 || gd !== 32'h0) begin failures++; $display("FAIL unmapped[%0d]: got %b/%h want 1/0", a, gv, gd); end
    end
  endtask

  task automatic test_reset_inflight();
    access(1, 1, 0, 4'd0, 0, gd, gv, ed, ev); checks++;
    if (gv !== 1'b0 || gd !== 32'h0) begin failures++; $display("FAIL read_dropped_by_reset: got %b/%h want 0/0", gv, gd); end
  endtask

  task automatic test_random();
    bit rd, wr;
    logic [3:0] a;
    for (int i = 0; i < 400; i++) begin
      rd = ($urandom % 2) == 0;
      wr = ($urandom % 3) == 0;
      a  = 4'($urandom_range(0, 15));
      access(0, rd, wr, a, $urandom, gd, gv, ed, ev); checks++;
      if (gv !== ev || gd !== ed) begin
        failures++; $display("FAIL random[%0d] addr=%0d rd=%0b wr=%0b: got %b/%h want %b/%h", i, a, rd, wr, gv, gd, ev, ed);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    user_w[0] = 32'h0BAD_F00D; user_w[1] = 32'h8765_0001;
    user_w[2] = 32'h1234_0002; user_w[3] = 32'hCAFE_0003;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = 4'd0; bus.writedata = 32'h0;
    model_reset(0);
    test_reset();
    test_id_caps();
    test_scratch();
    test_uptime_wrap();
    test_freeze_clear();
    test_rw_same();
    test_user();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
